// File: rtl/fifo_rd_stream_if.sv
// Read-port and output-stream bundle for the FIFO drain controller.
// Stream handshake: m_data is transferred on a rising rclk edge where m_valid
// and m_ready are both high; once m_valid is raised it stays high and m_data
// stays stable until that transfer happens. fifo_dout carries the word popped
// by the fifo_rd_en sampled high on the previous edge.
interface fifo_rd_stream_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  // Controller side: reads the FIFO and drives the stream.
  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  // Environment side: the FIFO read port plus the stream consumer.
  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller: turns the FIFO rd_en/empty/dout port into a
// valid/ready stream through a 2-entry prefetch buffer. Buffered plus
// in-flight words never exceed 2, so the buffer cannot overflow and the FIFO
// is never read while empty.
module fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic [1:0]       dbg_occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t              state;
  occ_t              state_nxt;
  logic              inflight;
  logic              push;
  logic              pop;
  logic [2:0]        credit;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;

  // Occupancy state register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy next state: push adds one, pop removes one, both cancel.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop) begin
          state_nxt = TWO;
        end else if (pop && !push) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (pop && !push) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Stream outputs, handshake decode and credit-limited read issue.
  always_comb begin
    bus.m_valid    = (state != EMPTY);
    bus.m_data     = head;
    pop            = bus.m_valid && bus.m_ready;
    push           = inflight;
    credit         = {1'b0, state} + {2'b00, inflight};
    bus.fifo_rd_en = enable && !bus.fifo_empty && !rrst &&
                     (credit < (3'd2 + {2'b00, pop}));
    busy           = (state != EMPTY) || inflight;
    dbg_occ        = state;
  end

  // A read issued this cycle returns data on the next edge.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd_en;
    end
  end

  // Count completed handoffs, wrapping naturally at 2^CNT_W.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Buffer storage: head is presented, tail queues behind it; a word returning
  // during reset is dropped because reset takes priority over push.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) head <= bus.fifo_dout;
        end
        ONE: begin
          if (push && pop) begin
            head <= bus.fifo_dout;
          end else if (push) begin
            tail <= bus.fifo_dout;
          end
        end
        TWO: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= bus.fifo_dout;
          end
        end
        default: begin
          head <= head;
        end
      endcase
    end
  end

  // Credit accounting must make a push into a full, non-draining buffer impossible.
  overflow_chk: assert property (@(posedge rclk) disable iff (rrst)
    !(push && !pop && state == TWO));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO source and an expected queue of
// words read but not yet delivered drive every per-cycle expectation.
module tb_fifo_rd_stream;

  logic        rclk;
  logic        rrst;
  logic        enable;
  logic [15:0] word_cnt;
  logic        busy;
  logic [1:0]  dbg_occ;

  fifo_rd_stream_if #(.DATA_W(8)) bus ();

  fifo_rd_stream #(.DATA_W(8), .CNT_W(16)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .enable   (enable),
    .bus      (bus.master),
    .word_cnt (word_cnt),
    .busy     (busy),
    .dbg_occ  (dbg_occ)
  );

  // Clock generation.
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  bit          prev_rd;
  bit          hold_empty;
  logic [15:0] cnt_model;
  int          n_checks;
  int          n_fail;
  int          rd_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic step();
    int         outstanding;
    int         buffered;
    bit         exp_valid;
    bit         exp_pop;
    bit         exp_rd;
    logic [7:0] w;
    bus.fifo_empty = (src_q.size() == 0) || hold_empty;
    #1;
    outstanding = exp_q.size();
    buffered    = outstanding - int'(prev_rd);
    exp_valid   = buffered > 0;
    exp_pop     = exp_valid && bus.m_ready;
    exp_rd      = !rrst && enable && !bus.fifo_empty && ((outstanding - int'(exp_pop)) < 2);
    check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
    check("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
    check("rd_while_empty", 32'(bus.fifo_rd_en && bus.fifo_empty), 32'(0));
    check("busy", 32'(busy), 32'(outstanding != 0));
    check("word_cnt", 32'(word_cnt), 32'(cnt_model));
    check("occ", 32'(dbg_occ), 32'(buffered));
    if (bus.fifo_rd_en === 1'b1) rd_seen++;
    w = 8'h00;
    if (rrst) begin
      exp_q.delete();
      cnt_model = '0;
    end else begin
      if (exp_pop) begin
        void'(exp_q.pop_front());
        cnt_model++;
      end
      if (exp_rd) begin
        w = src_q.pop_front();
        exp_q.push_back(w);
      end
    end
    @(posedge rclk);
    #1;
    bus.fifo_dout = exp_rd ? w : 8'($urandom);
    prev_rd = exp_rd;
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    bus.m_ready = 1'b0;
    step();
    rrst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    enable = 1'b1;
    bus.m_ready = 1'b1;
    hold_empty = 1'b0;
    i = 0;
    while (i < 200 && (exp_q.size() != 0 || src_q.size() != 0)) begin
      step();
      i++;
    end
    check({tag, "_timeout"}, 32'(exp_q.size() + src_q.size()), 32'(0));
    step();
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int start;
    int guard;
    rrst = 1'b1;
    enable = 1'b0;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout = 8'h00;
    prev_rd = 1'b0;
    hold_empty = 1'b0;
    cnt_model = '0;
    n_checks = 0;
    n_fail = 0;
    rd_seen = 0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    check("rst_m_valid", 32'(bus.m_valid), 32'(0));
    check("rst_m_data", 32'(bus.m_data), 32'(0));
    check("rst_word_cnt", 32'(word_cnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rrst = 1'b0;

    // Test 1: FIFO empty for 20 cycles.
    enable = 1'b1;
    bus.m_ready = 1'b1;
    start = rd_seen;
    repeat (20) step();
    check("t1_no_reads", 32'(rd_seen - start), 32'(0));

    // Test 2: three words streamed back to back.
    do_reset();
    src_q = '{8'h11, 8'h22, 8'h33};
    bus.m_ready = 1'b1;
    repeat (6) step();
    check("t2_word_cnt", 32'(word_cnt), 32'(3));

    // Test 3: consumer stalled, then released.
    do_reset();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    start = rd_seen;
    repeat (8) step();
    check("t3_stalled_reads", 32'(rd_seen - start), 32'(2));
    check("t3_head_hold", 32'(bus.m_data), 32'(8'h11));
    drain("t3");
    check("t3_word_cnt", 32'(word_cnt), 32'(5));

    // Test 5: enable dropped after two reads.
    do_reset();
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    bus.m_ready = 1'b1;
    start = rd_seen;
    guard = 0;
    while (rd_seen - start < 2 && guard < 20) begin
      step();
      guard++;
    end
    enable = 1'b0;
    repeat (6) step();
    check("t5_reads", 32'(rd_seen - start), 32'(2));
    check("t5_word_cnt", 32'(word_cnt), 32'(2));
    check("t5_busy", 32'(busy), 32'(0));
    drain("t5");
    check("t5_word_cnt_end", 32'(word_cnt), 32'(6));

    // Test 6: reset with a buffered word and a read in flight.
    do_reset();
    src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    enable = 1'b1;
    bus.m_ready = 1'b0;
    step();
    step();
    check("t6_pre_occ", 32'(dbg_occ), 32'(1));
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    check("t6_m_valid", 32'(bus.m_valid), 32'(0));
    check("t6_word_cnt", 32'(word_cnt), 32'(0));
    drain("t6");
    check("t6_word_cnt_end", 32'(word_cnt), 32'(2));

    // Test 4: random consumer stalls, empty flag and enable.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      while (src_q.size() < 4) src_q.push_back(8'($urandom));
      bus.m_ready = 1'($urandom_range(0, 1));
      hold_empty  = ($urandom_range(0, 9) < 3);
      enable      = ($urandom_range(0, 19) != 0);
      step();
    end
    drain("t4");
    check("t4_word_cnt", 32'(word_cnt), 32'(cnt_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
